// File: rtl/priority_83_encoder_if.sv
// priority_83_encoder_if: request/result bundle for the 8-to-3 priority encoder
//   en  encoder enable (master -> slave)
//   x   request vector, x[7] highest priority (master -> slave)
//   y   encoded index of highest asserted bit (slave -> master)
//   gs  group select, en and any request (slave -> master)
//   eo  enable out, en and no request (slave -> master)
interface priority_83_encoder_if;
   logic       en;
   logic [7:0] x;
   logic [2:0] y;
   logic       gs;
   logic       eo;
   modport master (output en, x, input y, gs, eo);
   modport slave (input en, x, output y, gs, eo);
endinterface

// File: rtl/priority_83_encoder.sv
// priority_83_encoder: 8-input to 3-bit priority encoder with enable, cascadable via gs/eo
//   clk  system clock, rising edge (unused when OUT_REG=0)
//   rst  synchronous active-high reset (unused when OUT_REG=0)
//   bus  slave side of priority_83_encoder_if (en, x in; y, gs, eo out)
//   OUT_REG  1: outputs registered with 1-cycle latency; 0: outputs combinational
module priority_83_encoder #(
   parameter bit OUT_REG = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   priority_83_encoder_if.slave bus
);
   logic [2:0] w_y;
   logic       w_gs;
   logic       w_eo;
   logic       w_any;
   always_comb begin
      w_any = |bus.x;
      w_y   = !bus.en  ? 3'd0 :
              bus.x[7] ? 3'd7 :
              bus.x[6] ? 3'd6 :
              bus.x[5] ? 3'd5 :
              bus.x[4] ? 3'd4 :
              bus.x[3] ? 3'd3 :
              bus.x[2] ? 3'd2 :
              bus.x[1] ? 3'd1 : 3'd0;
      w_gs  = bus.en & w_any;
      w_eo  = bus.en & ~w_any;
   end
   generate
      if (OUT_REG) begin : g_reg
         logic [2:0] r_y;
         logic       r_gs;
         logic       r_eo;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_y  <= 3'd0;
               r_gs <= 1'b0;
               r_eo <= 1'b0;
            end else begin
               r_y  <= w_y;
               r_gs <= w_gs;
               r_eo <= w_eo;
            end
         end
         assign bus.y  = r_y;
         assign bus.gs = r_gs;
         assign bus.eo = r_eo;
      end else begin : g_comb
         assign bus.y  = w_y;
         assign bus.gs = w_gs;
         assign bus.eo = w_eo;
      end
   endgenerate
endmodule

// File: tb/tb_priority_83_encoder.sv
// tb_priority_83_encoder: scoreboard bench for registered and combinational encoder variants
module tb_priority_83_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [4:0] q_exp[$];
   priority_83_encoder_if bus_r ();
   priority_83_encoder_if bus_c ();
   priority_83_encoder #(.OUT_REG(1'b1)) u_reg (.clk(clk), .rst(rst), .bus(bus_r));
   priority_83_encoder #(.OUT_REG(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus_c));
   always #5 clk = ~clk;
   function automatic logic [4:0] model(input logic r, input logic e, input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      if (r || !e) return 5'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) idx = 3'(i);
      return {idx, v != 8'h00, v == 8'h00};
   endfunction
   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got y=%0d gs=%b eo=%b, expected y=%0d gs=%b eo=%b",
                  tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
      end
   endtask
   task automatic step(input string tag, input logic r, input logic e, input logic [7:0] v);
      logic [4:0] exp;
      @(negedge clk);
      rst = r;
      bus_r.en = e;
      bus_r.x = v;
      q_exp.push_back(model(r, e, v));
      @(posedge clk);
      #1;
      if (q_exp.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         exp = q_exp.pop_front();
         chk(tag, {bus_r.y, bus_r.gs, bus_r.eo}, exp);
      end
   endtask
   task automatic comb(input string tag, input logic e, input logic [7:0] v);
      bus_c.en = e;
      bus_c.x = v;
      #1;
      chk(tag, {bus_c.y, bus_c.gs, bus_c.eo}, model(1'b0, e, v));
   endtask
   logic [7:0] walk[8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
   logic [7:0] multi[3] = '{8'hFF, 8'h3C, 8'h03};
   initial begin
      bus_r.en = 1'b1;
      bus_r.x = 8'hFF;
      bus_c.en = 1'b0;
      bus_c.x = 8'h00;
      step("reset0", 1'b1, 1'b1, 8'hFF);
      step("reset1", 1'b1, 1'b1, 8'hFF);
      step("release", 1'b0, 1'b1, 8'hFF);
      foreach (walk[i]) step($sformatf("walk%0d", i), 1'b0, 1'b1, walk[i]);
      foreach (multi[i]) step($sformatf("multi%0d", i), 1'b0, 1'b1, multi[i]);
      step("zero", 1'b0, 1'b1, 8'h00);
      step("disable", 1'b0, 1'b0, 8'hFF);
      step("reenable", 1'b0, 1'b1, 8'hFF);
      step("stream0", 1'b0, 1'b1, 8'h40);
      step("midrst", 1'b1, 1'b1, 8'h10);
      step("after_rst", 1'b0, 1'b1, 8'h10);
      for (int i = 0; i < 20; i++)
         step($sformatf("rand%0d", i), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
              8'($urandom_range(0, 255)));
      comb("comb_20", 1'b1, 8'h20);
      comb("comb_zero", 1'b1, 8'h00);
      comb("comb_dis", 1'b0, 8'hFF);
      comb("comb_ff", 1'b1, 8'hFF);
      comb("comb_01", 1'b1, 8'h01);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
